// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// loads the IF/ID pipeline register. Supports stall, flush, redirect and a fault halt.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [31:0] word_idx;
  logic [31:0] pc_plus4;
  logic        bad_pc;
  logic        fetch_ok;

  assign word_idx = {2'b00, pc_q[31:2]};
  assign pc_plus4 = pc_q + 32'd4;
  assign bad_pc   = (pc_q[1:0] != 2'b00) || (word_idx >= IMEM_LIMIT);
  assign fetch_ok = (state_q == ST_FETCH) && !bad_pc;

  // PC and control state; a redirect is honoured in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        if (redirect) pc_d = redirect_pc;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (bad_pc) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          fault_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // IF/ID: flush beats stall, stall beats everything else; a bubble is all zeros.
  always_comb begin
    if_id_pc_d    = 32'h0;
    if_id_pc4_d   = 32'h0;
    if_id_instr_d = 32'h0;
    if_id_valid_d = 1'b0;
    if (flush) begin
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
    end else if (redirect) begin
      if_id_valid_d = 1'b0;
    end else if (fetch_ok) begin
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_re     = fetch_ok && !rst;
  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_fault = fault_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: IF/ID contents are predicted into a
// scoreboard queue as each step is driven and compared after the clock edge.
module tb_if_fetch_stage;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // {valid, pc, instr}
  logic [64:0] exp_q[$];

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory contents: never zero, distinct per word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[15:0]} ^ 32'h1300_0013;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  function automatic logic [64:0] fetched(input logic [31:0] a);
    return {1'b1, a, word_at(a)};
  endfunction

  localparam logic [64:0] BUBBLE = 65'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic f, input logic r,
                      input logic [31:0] rpc, input logic [64:0] exp);
    logic [64:0] e;
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rpc;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, e[64]});
      check("if_id_pc", if_id_pc, e[63:32]);
      check("if_id_instr", if_id_instr, e[31:0]);
      check("if_id_pc4", if_id_pc4, e[64] ? e[63:32] + 32'd4 : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] mpc;
    logic [64:0] last;
    rst = 1'b1; stall = 1'b1; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_imem_re", {31'h0, imem_re}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, S_BOOT});
    rst = 1'b0;

    // Boot cycle, then A, B
    check("boot_imem_re", {31'h0, imem_re}, 32'h0);
    step(0, 0, 0, 0, BUBBLE);
    check("boot_pc", pc, 32'h0);
    check("fetch_imem_re", {31'h0, imem_re}, 32'h1);
    check("imem_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, fetched(32'h0));
    step(0, 0, 0, 0, fetched(32'h4));
    check("pc_before_stall", pc, 32'h8);

    // Two stall cycles hold B, then C and the word at 12
    step(1, 0, 0, 0, fetched(32'h4));
    check("stall1_pc", pc, 32'h8);
    step(1, 0, 0, 0, fetched(32'h4));
    check("stall2_pc", pc, 32'h8);
    step(0, 0, 0, 0, fetched(32'h8));
    step(0, 0, 0, 0, fetched(32'hC));
    check("pc_0x10", pc, 32'h10);

    // Redirect to 0x40
    step(0, 0, 1, 32'h40, BUBBLE);
    check("redirect_pc", pc, 32'h40);
    step(0, 0, 0, 0, fetched(32'h40));

    // stall + flush: bubble while pc holds
    step(1, 1, 0, 0, BUBBLE);
    check("stall_flush_pc", pc, 32'h44);
    step(0, 0, 0, 0, fetched(32'h44));

    // stall + redirect without flush: pc moves, IF/ID holds
    step(1, 0, 1, 32'h80, fetched(32'h44));
    check("stall_redirect_pc", pc, 32'h80);
    step(0, 0, 0, 0, fetched(32'h80));

    // Misaligned redirect target
    step(0, 0, 1, 32'h2002, BUBBLE);
    check("misaligned_imem_re", {31'h0, imem_re}, 32'h0);
    check("misaligned_fault_pre", {31'h0, fetch_fault}, 32'h0);
    step(0, 0, 0, 0, BUBBLE);
    check("misaligned_fault", {31'h0, fetch_fault}, 32'h1);
    check("misaligned_state", {30'h0, dbg_state}, {30'h0, S_HALT});
    check("misaligned_pc_hold", pc, 32'h2002);
    step(0, 0, 0, 0, BUBBLE);
    check("halt_imem_re", {31'h0, imem_re}, 32'h0);
    check("halt_state", {30'h0, dbg_state}, {30'h0, S_HALT});
    step(0, 0, 1, 32'h100, BUBBLE);
    check("recover_fault", {31'h0, fetch_fault}, 32'h0);
    check("recover_state", {30'h0, dbg_state}, {30'h0, S_FETCH});
    step(0, 0, 0, 0, fetched(32'h100));

    // Last valid word, then out of range
    step(0, 0, 1, 32'h1FF8, BUBBLE);
    step(0, 0, 0, 0, fetched(32'h1FF8));
    step(0, 0, 0, 0, fetched(32'h1FFC));
    check("end_pc", pc, 32'h2000);
    check("end_imem_re", {31'h0, imem_re}, 32'h0);
    step(0, 0, 0, 0, BUBBLE);
    check("end_fault", {31'h0, fetch_fault}, 32'h1);
    check("end_state", {30'h0, dbg_state}, {30'h0, S_HALT});

    // Reset mid-HALT
    rst = 1'b1;
    @(posedge clk); #1;
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_state", {30'h0, dbg_state}, {30'h0, S_BOOT});
    check("halt_rst_fault", {31'h0, fetch_fault}, 32'h0);
    rst = 1'b0;

    // Random stalls: in-order fetch from 0 with IF/ID held on stall cycles
    step(0, 0, 0, 0, BUBBLE);
    mpc  = 32'h0;
    last = BUBBLE;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1, 0, 0, 0, last);
      end else begin
        last = fetched(mpc);
        mpc  = mpc + 32'd4;
        step(0, 0, 0, 0, last);
      end
      check("rand_pc", pc, mpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
